// File: rtl/rf_wren_gate_check.sv
// rf_wren_gate_check: write-address decode, per-word clock gates and strobe
// checker for a latch-based register file. Optional macro: RF_WREN_CHECK_EN.
//
// Ports:
//   clk_int      block clock; mem_clk_o bits are gated copies of it
//   rst_ni       async active-low reset (clears err_sticky_o only)
//   test_en_i    forces every clock gate open
//   we_i         write enable
//   waddr_i      write word address
//   wen_onehot_o decoded one-hot word strobe
//   mem_clk_o    per-word gated clocks
//   err_o        combinational strobe-check error
//   err_sticky_o registered sticky copy of err_o
module rf_wren_gate_check #(
  parameter int unsigned AddrWidth = 5,
  parameter bit          GateWord0 = 1'b0,
  localparam int unsigned NumWords = 2 ** AddrWidth
) (
  input  logic                 clk_int,
  input  logic                 rst_ni,
  input  logic                 test_en_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  output logic [NumWords-1:0]  wen_onehot_o,
  output logic [NumWords-1:0]  mem_clk_o,
  output logic                 err_o,
  output logic                 err_sticky_o
);

  logic [NumWords-1:0] wen;

  always_comb begin
    wen = '0;
    wen[waddr_i] = we_i;
  end

  assign wen_onehot_o = wen;

  for (genvar i = 0; i < NumWords; i++) begin : g_gate
    if (i == 0 && !GateWord0) begin : g_tie
      assign mem_clk_o[i] = 1'b0;
    end else begin : g_cg
      logic en_l;
      // Enable only moves while clk_int is low, so the AND cannot glitch.
      always_latch begin
        if (!clk_int) en_l <= wen[i] | test_en_i;
      end
      assign mem_clk_o[i] = clk_int & en_l;
    end
  end

`ifdef RF_WREN_CHECK_EN
  // Kept buffer so the checker observes the physical strobe net and
  // cannot be folded back into the decoder.
  (* keep = "true", dont_touch = "true" *)
  logic [NumWords-1:0] oh;
  assign oh = wen;

  logic err_multi;
  logic err_en;
  logic err_addr;

  assign err_multi = |(oh & (oh - NumWords'(1)));
  assign err_en    = (|oh) != we_i;
  assign err_addr  = we_i & ~oh[waddr_i];
  assign err_o     = err_multi | err_en | err_addr;

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      err_sticky_o <= 1'b0;
    end else if (err_o) begin
      err_sticky_o <= 1'b1;
    end
  end
`else
  assign err_o        = 1'b0;
  assign err_sticky_o = 1'b0;

  logic unused_rst;
  assign unused_rst = rst_ni;

  if (!GateWord0) begin : g_unused_w0
    logic unused_w0;
    assign unused_w0 = wen[0];
  end
`endif

endmodule

// File: tb/tb_rf_wren_gate_check.sv
// tb_rf_wren_gate_check: directed self-checking bench for rf_wren_gate_check
// (AddrWidth=5, GateWord0=0).
module tb_rf_wren_gate_check;

  logic        clk_int = 1'b0;
  logic        rst_ni;
  logic        test_en_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wen_onehot_o;
  logic [31:0] mem_clk_o;
  logic        err_o;
  logic        err_sticky_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk_int = ~clk_int;

  rf_wren_gate_check #(
    .AddrWidth(5),
    .GateWord0(1'b0)
  ) dut (
    .clk_int     (clk_int),
    .rst_ni      (rst_ni),
    .test_en_i   (test_en_i),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wen_onehot_o(wen_onehot_o),
    .mem_clk_o   (mem_clk_o),
    .err_o       (err_o),
    .err_sticky_o(err_sticky_o)
  );

  // Capture gated clocks in the high phase and the following low phase.
  // Returns 1 ns after the falling edge, i.e. inside the low phase.
  task automatic tick();
    @(posedge clk_int);
    #2;
    hi = mem_clk_o;
    @(negedge clk_int);
    #1;
    lo = mem_clk_o;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    test_en_i = 1'b0;
    we_i = 1'b0;
    waddr_i = '0;
    #3;
    checks++;
    if (err_sticky_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_sticky got=%b exp=0", err_sticky_o);
    end
    @(negedge clk_int);
    #1;
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (hi !== 32'h0 || lo !== 32'h0) begin
        errors++;
        $display("FAIL idle_clk c=%0d hi=%h lo=%h exp=0", c, hi, lo);
      end
      checks++;
      if (wen_onehot_o !== 32'h0 || err_o !== 1'b0 ||
          err_sticky_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_out wen=%h err=%b st=%b exp=0/0/0",
                 wen_onehot_o, err_o, err_sticky_o);
      end
    end
  endtask

  task automatic test_write(input logic [4:0] a, input logic [31:0] exp);
    int pulses;
    we_i = 1'b1;
    waddr_i = a;
    #1;
    checks++;
    if (wen_onehot_o !== exp || err_o !== 1'b0) begin
      errors++;
      $display("FAIL wr_dec a=%0d wen=%h err=%b exp=%h/0",
               a, wen_onehot_o, err_o, exp);
    end
    pulses = 0;
    tick();
    if (hi[a]) pulses++;
    checks++;
    if (hi !== (a == 0 ? 32'h0 : exp) || lo !== 32'h0) begin
      errors++;
      $display("FAIL wr_clk a=%0d hi=%h lo=%h exp=%h/0",
               a, hi, lo, (a == 0 ? 32'h0 : exp));
    end
    we_i = 1'b0;
    tick();
    if (hi[a]) pulses++;
    checks++;
    if (pulses !== (a == 0 ? 0 : 1) || hi !== 32'h0) begin
      errors++;
      $display("FAIL wr_pulses a=%0d got=%0d hi=%h exp=%0d",
               a, pulses, hi, (a == 0 ? 0 : 1));
    end
  endtask

  task automatic test_high_phase_change();
    we_i = 1'b1;
    waddr_i = 5'd2;
    @(posedge clk_int);
    #2;
    waddr_i = 5'd9;
    #1;
    checks++;
    if (mem_clk_o !== 32'h4) begin
      errors++;
      $display("FAIL hp_hold got=%h exp=00000004", mem_clk_o);
    end
    @(negedge clk_int);
    #1;
    tick();
    checks++;
    if (hi !== 32'h200) begin
      errors++;
      $display("FAIL hp_next got=%h exp=00000200", hi);
    end
    we_i = 1'b0;
    tick();
  endtask

  task automatic test_test_en();
    test_en_i = 1'b1;
    we_i = 1'b0;
    tick();
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0) begin
      errors++;
      $display("FAIL ten_idle hi=%h lo=%h exp=fffffffe/0", hi, lo);
    end
    we_i = 1'b1;
    waddr_i = 5'd3;
    tick();
    checks++;
    if (hi !== 32'hFFFF_FFFE || wen_onehot_o !== 32'h8) begin
      errors++;
      $display("FAIL ten_wr hi=%h wen=%h exp=fffffffe/8", hi, wen_onehot_o);
    end
    test_en_i = 1'b0;
    we_i = 1'b0;
    tick();
    checks++;
    if (hi !== 32'h0) begin
      errors++;
      $display("FAIL ten_off hi=%h exp=0", hi);
    end
  endtask

  task automatic test_faults();
`ifdef RF_WREN_CHECK_EN
    we_i = 1'b1;
    waddr_i = 5'd3;
    force dut.oh = 32'h88;
    #1;
    checks++;
    if (err_o !== 1'b1 || err_sticky_o !== 1'b0) begin
      errors++;
      $display("FAIL f_multi err=%b st=%b exp=1/0", err_o, err_sticky_o);
    end
    tick();
    release dut.oh;
    we_i = 1'b0;
    #1;
    checks++;
    if (err_sticky_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL f_sticky st=%b err=%b exp=1/0", err_sticky_o, err_o);
    end
    tick();
    checks++;
    if (err_sticky_o !== 1'b1) begin
      errors++;
      $display("FAIL f_hold st=%b exp=1", err_sticky_o);
    end
    force dut.oh = 32'h10;
    #1;
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL f_en err=%b exp=1", err_o);
    end
    we_i = 1'b1;
    waddr_i = 5'd6;
    #1;
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL f_addr err=%b exp=1", err_o);
    end
    release dut.oh;
    we_i = 1'b0;
    #1;
`else
    we_i = 1'b1;
    waddr_i = 5'd3;
    #1;
    tick();
    checks++;
    if (err_o !== 1'b0 || err_sticky_o !== 1'b0) begin
      errors++;
      $display("FAIL f_off3 err=%b st=%b exp=0/0", err_o, err_sticky_o);
    end
    we_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL f_off0 err=%b exp=0", err_o);
    end
`endif
    // Mid-operation reset: sticky clears at once, gates keep working.
    we_i = 1'b1;
    waddr_i = 5'd7;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (err_sticky_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid st=%b exp=0", err_sticky_o);
    end
    tick();
    checks++;
    if (hi !== 32'h80) begin
      errors++;
      $display("FAIL rst_gate hi=%h exp=00000080", hi);
    end
    we_i = 1'b0;
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_write(5'd5, 32'h0000_0020);
    test_write(5'd0, 32'h0000_0001);
    test_write(5'd31, 32'h8000_0000);
    test_write(5'd1, 32'h0000_0002);
    test_high_phase_change();
    test_test_en();
    test_faults();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
